// File: rtl/spi_slave_core.sv
// SPI mode-0 slave datapath behind the sck/sdi/cs synchronizer: rx word assembly, one-entry tx buffer.
// Optional sticky receive-overrun detection is enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_core #(
    parameter int                    WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] TX_IDLE_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_in,
    output logic                  sdo,
    output logic                  cs_active,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic                  rx_overrun,
    input  logic                  overrun_clr
`endif
);

    localparam int              CNT_W    = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_next;
    logic                    sck_prev;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    word_done;
    logic [WORD_WIDTH-1:0]   rx_shift;
    logic [WORD_WIDTH-1:0]   tx_shift;
    logic [WORD_WIDTH-1:0]   tx_buf;
    logic                    tx_full;

    logic                    rise, fall, start, stop, act;
    logic                    word_complete, rx_accept, tx_load;
    logic [WORD_WIDTH-1:0]   rx_word;

    assign rise          = sck_in & ~sck_prev;
    assign fall          = ~sck_in & sck_prev;
    assign start         = (state == IDLE) & ~cs_in;
    assign stop          = (state == ACTIVE) & cs_in;
    assign act           = (state == ACTIVE) & ~cs_in;
    assign word_complete = act & rise & (bit_cnt == LAST_BIT);
    assign rx_word       = {rx_shift[WORD_WIDTH-2:0], sdi_in};
    assign tx_load       = start | (act & fall & word_done);

`ifdef SPI_SLAVE_OVERRUN_EN
    // A finished word is dropped when the previous one is still pending and not taken this cycle.
    assign rx_accept = word_complete & ~(rx_valid & ~rx_ready);
`else
    assign rx_accept = word_complete;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_in) state_next = ACTIVE;
            ACTIVE:  if (cs_in)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cs_active = (state == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_prev  <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= TX_IDLE_VALUE;
            tx_full   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            sck_prev <= sck_in;

            if (start) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end else if (stop) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                word_done <= 1'b0;
            end else if (act) begin
                if (rise) begin
                    rx_shift <= rx_word;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (fall && word_done) word_done <= 1'b0;
            end

            if (tx_load)          tx_shift <= tx_full ? tx_buf : TX_IDLE_VALUE;
            else if (act && fall) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};

            // An idle-value load leaves the buffer empty, so a same-cycle write must still land.
            if (tx_load && tx_full)        tx_full <= 1'b0;
            else if (tx_valid && !tx_full) tx_full <= 1'b1;

            if (rx_accept) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // NOTE: buffer data needs no reset; tx_full alone decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (tx_valid && !tx_full) tx_buf <= tx_data;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                 rx_overrun <= 1'b0;
        else if (word_complete && !rx_accept)       rx_overrun <= 1'b1;
        else if (overrun_clr)                       rx_overrun <= 1'b0;
    end
`endif

    assign sdo      = tx_shift[WORD_WIDTH-1];
    assign tx_ready = ~tx_full;

endmodule
